// File: rtl/csa_accum_resolve.sv
// csa_accum_resolve
//   Accumulates carry-save (PS/PC) beats from the multiplier's Wallace tree in
//   redundant form using 4:2 compression, so the accumulate loop contains no
//   carry-propagate path. On a beat marked last, the redundant pair is
//   resolved with a single registered carry-propagate add. The binary result
//   is then offered on a valid/ready output.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   PS/PC beat present
//   in_ready   block accepts a beat this cycle (ACCUM state)
//   in_ps      partial sum, bit i has weight 2^i
//   in_pc      partial carry, bit i has weight 2^(i+1) (shift applied here)
//   in_clear   beat starts a new accumulation
//   in_last    resolve after this beat
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_sum    resolved accumulation, mod 2^ACC_W
//   out_ovf    unsigned overflow occurred during this accumulation
module csa_accum_resolve #(
  parameter int N     = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_ps,
  input  logic [N-1:0]     in_pc,
  input  logic             in_clear,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUT} state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc_s, acc_c;
  logic             ovf_r;

  logic [ACC_W-1:0] s0, c0, x, y;
  logic [ACC_W-1:0] s1, k1, s2, k2;
  logic             drop;
  logic             accept;
  logic [ACC_W:0]   total;

  // One full-adder layer across the word: returns {sum, carry}, where the
  // carry vector is still unshifted (bit i carries weight 2^(i+1)).
  function automatic logic [2*ACC_W-1:0] csa(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic [ACC_W-1:0] c
  );
    logic [ACC_W-1:0] s, k;
    s = a ^ b ^ c;
    k = (a & b) | (a & c) | (b & c);
    return {s, k};
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign accept    = in_valid & in_ready;

  // Compression: clear zeroes the old pair so a new stream starts from zero.
  always_comb begin
    s0       = in_clear ? '0 : acc_s;
    c0       = in_clear ? '0 : acc_c;
    x        = ACC_W'(in_ps);
    y        = ACC_W'({in_pc, 1'b0});
    {s1, k1} = csa(s0, c0, x);
    {s2, k2} = csa(s1, k1 << 1, y);
    // A carry leaving the top bit is a lost 2^ACC_W; remember it as overflow.
    drop     = k1[ACC_W-1] | k2[ACC_W-1];
    total    = {1'b0, acc_s} + {1'b0, acc_c};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nxt = RESOLVE;
      RESOLVE: state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulate on accepted beats; resolve and clear in RESOLVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      acc_s   <= '0;
      acc_c   <= '0;
      ovf_r   <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc_s <= s2;
        acc_c <= k2 << 1;
        ovf_r <= (in_clear ? 1'b0 : ovf_r) | drop;
      end else if (state == RESOLVE) begin
        out_sum <= total[ACC_W-1:0];
        out_ovf <= ovf_r | total[ACC_W];
        acc_s   <= '0;
        acc_c   <= '0;
        ovf_r   <= 1'b0;
      end
    end
  end

endmodule
